// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// -------------
// Shares the single register-file write port between two writeback sources.
// Source A carries ALU results and source M carries memory-load results.
// Each source uses a valid/ready handshake, and at most one request is
// granted per cycle. The granted write is registered, then presented to the
// register file on the following cycle (RD/WRD/Wreg).
//
// Arbitration:
//   - A single requester always wins.
//   - Both requesting the same rd: M wins, because the load is older.
//     rr_last is then set to 1.
//   - Both requesting different rd: the source that did not win the last
//     contention wins, and rr_last records the winner.
//   - A grant to rd==0 consumes the slot but never raises Wreg.
//
// Optional build macro: RF_WB_BYPASS_EN
//   When it is defined, the block adds combinational read forwarding of the
//   registered-but-uncommitted write onto the two register-file read ports.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   a_valid/a_rd/a_data ALU write request      a_ready  accepted this cycle
//   m_valid/m_rd/m_data load write request     m_ready  accepted this cycle
//   RD, WRD, Wreg       register-file write address / data / enable
//   conflict_cnt        saturating count of cycles with both valids high
//   rr_last             last contention winner (0=A, 1=M)
//   R1, R2, s1_rf, s2_rf, s1_fwd, s2_fwd   (RF_WB_BYPASS_EN only)
module rf_wb_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          m_valid,
  input  logic [AW-1:0] m_rd,
  input  logic [DW-1:0] m_data,
  output logic          m_ready,
  output logic [AW-1:0] RD,
  output logic [DW-1:0] WRD,
  output logic          Wreg,
  output logic [CW-1:0] conflict_cnt,
  output logic          rr_last
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0] R1,
  input  logic [AW-1:0] R2,
  input  logic [DW-1:0] s1_rf,
  input  logic [DW-1:0] s2_rf,
  output logic [DW-1:0] s1_fwd,
  output logic [DW-1:0] s2_fwd
`endif
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_M    = 2'd2
  } grant_e;

  grant_e          grant;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            both_valid;

  logic            wreg_q,  wreg_d;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   data_q;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            rr_q,    rr_d;

  // Saturating increment for the contention counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) return v;
    return v + CW'(1);
  endfunction

  assign both_valid = a_valid && m_valid;

  // Grant decision (combinational; no grants while reset is held)
  always_comb begin
    grant = GNT_NONE;
    rr_d  = rr_q;
    if (!reset) begin
      if (both_valid) begin
        if (a_rd == m_rd) begin
          grant = GNT_M;
        end else if (rr_q) begin
          grant = GNT_A;
        end else begin
          grant = GNT_M;
        end
        rr_d = (grant == GNT_M);
      end else if (a_valid) begin
        grant = GNT_A;
      end else if (m_valid) begin
        grant = GNT_M;
      end
    end
  end

  assign a_ready  = (grant == GNT_A);
  assign m_ready  = (grant == GNT_M);
  assign sel_rd   = (grant == GNT_M) ? m_rd   : a_rd;
  assign sel_data = (grant == GNT_M) ? m_data : a_data;

  // A write to register 0 is swallowed here so the register file never sees it.
  assign wreg_d = (grant != GNT_NONE) && (sel_rd != '0);
  assign cnt_d  = both_valid ? sat_inc(cnt_q) : cnt_q;

  // Output stage: the granted write is registered and committed next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wreg_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      rr_q   <= 1'b1;
    end else begin
      wreg_q <= wreg_d;
      if (grant != GNT_NONE) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  assign RD           = rd_q;
  assign WRD          = data_q;
  assign Wreg         = wreg_q;
  assign conflict_cnt = cnt_q;
  assign rr_last      = rr_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the pending write. The reset term keeps a write that is being
  // discarded from leaking through during the reset cycle.
  assign s1_fwd = (!reset && wreg_q && (rd_q == R1) && (R1 != '0)) ? data_q : s1_rf;
  assign s2_fwd = (!reset && wreg_q && (rd_q == R2) && (R2 != '0)) ? data_q : s2_rf;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CW = 4;   // narrow counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, m_valid;
  logic [AW-1:0] a_rd, m_rd;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready;
  logic [AW-1:0] RD;
  logic [DW-1:0] WRD;
  logic          Wreg;
  logic [CW-1:0] conflict_cnt;
  logic          rr_last;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0] R1, R2;
  logic [DW-1:0] s1_rf, s2_rf, s1_fwd, s2_fwd;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .RD(RD), .WRD(WRD), .Wreg(Wreg),
    .conflict_cnt(conflict_cnt), .rr_last(rr_last)
`ifdef RF_WB_BYPASS_EN
    , .R1(R1), .R2(R2), .s1_rf(s1_rf), .s2_rf(s2_rf),
    .s1_fwd(s1_fwd), .s2_fwd(s2_fwd)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit            mdl_wreg;
  logic [AW-1:0] mdl_rd;
  logic [DW-1:0] mdl_wrd;
  int            mdl_cnt;
  bit            mdl_rr;      // who won the last contention (1 = load)

  // Winner from the rules: 0 none, 1 ALU, 2 load.
  function automatic int winner();
    if (reset) return 0;
    if (a_valid && m_valid) begin
      if (a_rd == m_rd) return 2;      // older load lands first
      return mdl_rr ? 1 : 2;           // the other side's turn
    end
    if (a_valid) return 1;
    if (m_valid) return 2;
    return 0;
  endfunction

  task automatic model_edge(input int w);
    if (reset) begin
      mdl_wreg = 0; mdl_rd = '0; mdl_wrd = '0; mdl_cnt = 0; mdl_rr = 1;
    end else begin
      if (a_valid && m_valid) begin
        if (mdl_cnt < (1 << CW) - 1) mdl_cnt = mdl_cnt + 1;
        mdl_rr = (w == 2);
      end
      if (w == 1) begin mdl_rd = a_rd; mdl_wrd = a_data; end
      if (w == 2) begin mdl_rd = m_rd; mdl_wrd = m_data; end
      mdl_wreg = (w != 0) && (mdl_rd != '0);
    end
  endtask

  // One clock cycle with the current inputs, checked against the model.
  task automatic step(output int w);
    #2;
    w = winner();
    check("rnd.a_ready", a_ready, (w == 1));
    check("rnd.m_ready", m_ready, (w == 2));
    @(posedge clk);
    model_edge(w);
    #1;
    check("rnd.Wreg", Wreg, mdl_wreg);
    check("rnd.cnt", conflict_cnt, mdl_cnt);
    check("rnd.rr_last", rr_last, mdl_rr);
    if (mdl_wreg) begin
      check("rnd.RD", RD, mdl_rd);
      check("rnd.WRD", WRD, mdl_wrd);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = '0; a_data = '0;
    m_valid = 0; m_rd = '0; m_data = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    @(posedge clk); #1;
    reset = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            av; logic [AW-1:0] ard; logic [DW-1:0] adat;
    bit            mv; logic [AW-1:0] mrd; logic [DW-1:0] mdat;
    bit            e_ar; bit e_mr;
    bit            e_wreg; bit chk_addr;
    logic [AW-1:0] e_rd; logic [DW-1:0] e_wrd;
    int            e_cnt; bit e_rr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int w;
    reset = 1;
    idle_inputs();
`ifdef RF_WB_BYPASS_EN
    R1 = '0; R2 = '0; s1_rf = '0; s2_rf = '0;
`endif

    tbl[0] = '{1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 0, 1'b1};
    tbl[1] = '{1'b0, 6'd0, 32'h0,        1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 0, 1'b1};
    tbl[2] = '{1'b1, 6'd3, 32'h11,       1'b1, 6'd4, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 6'd3, 32'h11, 1, 1'b0};
    tbl[3] = '{1'b1, 6'd3, 32'h11,       1'b1, 6'd4, 32'h22, 1'b0, 1'b1, 1'b1, 1'b1, 6'd4, 32'h22, 2, 1'b1};
    tbl[4] = '{1'b1, 6'd7, 32'hAA,       1'b1, 6'd7, 32'hBB, 1'b0, 1'b1, 1'b1, 1'b1, 6'd7, 32'hBB, 3, 1'b1};
    tbl[5] = '{1'b1, 6'd7, 32'hAA,       1'b0, 6'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 6'd7, 32'hAA, 3, 1'b1};
    tbl[6] = '{1'b0, 6'd0, 32'h0,        1'b1, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 3, 1'b1};
    tbl[7] = '{1'b0, 6'd0, 32'h0,        1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 3, 1'b1};

    // reset state
    @(posedge clk); #1;
    check("rst.Wreg", Wreg, 0);
    check("rst.RD", RD, 0);
    check("rst.WRD", WRD, 0);
    check("rst.cnt", conflict_cnt, 0);
    check("rst.rr_last", rr_last, 1);
    a_valid = 1; m_valid = 1; #2;
    check("rst.a_ready", a_ready, 0);
    check("rst.m_ready", m_ready, 0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].adat;
      m_valid = tbl[i].mv; m_rd = tbl[i].mrd; m_data = tbl[i].mdat;
      #2;
      check($sformatf("v%0d.a_ready", i), a_ready, tbl[i].e_ar);
      check($sformatf("v%0d.m_ready", i), m_ready, tbl[i].e_mr);
      @(posedge clk); #1;
      check($sformatf("v%0d.Wreg", i), Wreg, tbl[i].e_wreg);
      check($sformatf("v%0d.cnt", i), conflict_cnt, tbl[i].e_cnt);
      check($sformatf("v%0d.rr_last", i), rr_last, tbl[i].e_rr);
      if (tbl[i].chk_addr) begin
        check($sformatf("v%0d.RD", i), RD, tbl[i].e_rd);
        check($sformatf("v%0d.WRD", i), WRD, tbl[i].e_wrd);
      end
    end

    // Continuous dual contention: strict alternation A,M,... and saturation.
    do_reset();
    a_valid = 1; a_rd = 6'd1; a_data = 32'h10;
    m_valid = 1; m_rd = 6'd2; m_data = 32'h20;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("alt%0d.RD", i), RD, (i % 2 == 0) ? 6'd1 : 6'd2);
      check($sformatf("alt%0d.Wreg", i), Wreg, 1);
    end
    check("sat.cnt", conflict_cnt, (1 << CW) - 1);

    // Reset mid-flight discards the registered write.
    do_reset();
    a_valid = 1; a_rd = 6'd9; a_data = 32'h99;
    #2; check("mid.a_ready", a_ready, 1);
    @(posedge clk); #1;
    check("mid.Wreg_pending", Wreg, 1);
    check("mid.RD_pending", RD, 9);
    reset = 1; m_valid = 1; m_rd = 6'd3;
    #2;
    check("mid.a_ready_rst", a_ready, 0);
    check("mid.m_ready_rst", m_ready, 0);
    @(posedge clk); #1;
    check("mid.Wreg", Wreg, 0);
    check("mid.RD", RD, 0);
    check("mid.cnt", conflict_cnt, 0);
    check("mid.rr_last", rr_last, 1);
    reset = 0; idle_inputs();

`ifdef RF_WB_BYPASS_EN
    do_reset();
    a_valid = 1; a_rd = 6'd12; a_data = 32'h1234;
    @(posedge clk); #1;
    a_valid = 0;
    R1 = 6'd12; s1_rf = 32'h0; R2 = 6'd12; s2_rf = 32'h5;
    #2;
    check("byp.s1_hit", s1_fwd, 32'h1234);
    check("byp.s2_hit", s2_fwd, 32'h1234);
    R1 = 6'd0; s1_rf = 32'h55; R2 = 6'd11;
    #1;
    check("byp.s1_r0", s1_fwd, 32'h55);
    check("byp.s2_miss", s2_fwd, 32'h5);
    reset = 1; R1 = 6'd12; #1;
    check("byp.s1_rst", s1_fwd, 32'h55);
    @(posedge clk); #1;
    reset = 0; R1 = '0; R2 = '0;
`endif

    // Randomized traffic against the reference model; requesters hold
    // valid/rd/data stable until accepted.
    do_reset();
    mdl_wreg = 0; mdl_rd = '0; mdl_wrd = '0; mdl_cnt = 0; mdl_rr = 1;
    w = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      if (!a_valid || w == 1) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd = AW'($urandom_range(0, 3));
        a_data = $urandom;
      end
      if (!m_valid || w == 2) begin
        m_valid = ($urandom_range(0, 2) != 0);
        m_rd = AW'($urandom_range(0, 3));
        m_data = $urandom;
      end
      step(w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
